aes_kexp_seq: RTL and testbench

//  Iterative AES key expansion (FIPS-197 sec 5.2): accepts a cipher key, computes one

---
 rtl/aes_kexp_seq.sv | 162 ++++++++++++++++
 tb/tb_aes_kexp_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kexp_seq.sv
// rtl/aes_kexp_seq.sv - iterative AES key expansion, one schedule word per clock
// Optional feature macro: AES_KEXP_ZEROIZE_EN (clear schedule words >= Nk on reset and accept)

module aes_kexp_seq #(
    parameter int Nb = 4,
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Key_valid,
    output logic        Key_ready,
    input  logic [7:0]  Key [0:4*Nk-1],
    output logic [31:0] KExp [0:Nb*(Nr+1)-1],
    output logic        KExp_valid
);

    localparam int NW = Nb * (Nr + 1);
    localparam int IW = $clog2(NW + 1);
    localparam int KW = 3;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t        state, state_next;
    logic [IW-1:0] i;
    logic [KW-1:0] k;
    logic [7:0]    rcon;
    logic [31:0]   w [0:NW-1];

    logic          accept;
    logic          last;
    logic [IW-1:0] i_prev, i_back;
    logic [31:0]   w_prev, w_back, temp, w_new;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Key_ready  = 1'b0;
        last       = (i == IW'(NW - 1));
        case (state)
            IDLE:    Key_ready = 1'b1;
            EXPAND:  if (last) state_next = DONE;
            DONE:    Key_ready = 1'b1;
            default: state_next = IDLE;
        endcase
        accept = Key_valid & Key_ready;
        if (accept) begin
            state_next = EXPAND;
        end
    end

    // w[i-1] and w[i-Nk] are picked by compare-select so an idle i never forms an out-of-range index
    always_comb begin
        i_prev = i - IW'(1);
        i_back = i - IW'(Nk);
        w_prev = '0;
        w_back = '0;
        for (int j = 0; j < NW; j++) begin
            if (IW'(j) == i_prev) w_prev = w[j];
            if (IW'(j) == i_back) w_back = w[j];
        end
        temp = w_prev;
        if (k == '0) begin
            temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h0};
        end else if (Nk > 6 && k == KW'(4)) begin
            temp = sub_word(w_prev);
        end
        w_new = w_back ^ temp;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            i          <= '0;
            k          <= '0;
            rcon       <= 8'h01;
            KExp_valid <= 1'b0;
        end else if (accept) begin
            i          <= IW'(Nk);
            k          <= '0;
            rcon       <= 8'h01;
            KExp_valid <= 1'b0;
        end else if (state == EXPAND) begin
            i <= i + IW'(1);
            k <= (k == KW'(Nk - 1)) ? '0 : k + KW'(1);
            if (k == '0) begin
                rcon <= xtime(rcon);
            end
            if (last) begin
                KExp_valid <= 1'b1;
            end
        end
    end

`ifdef AES_KEXP_ZEROIZE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < NW; j++) w[j] <= '0;
        end else if (accept) begin
            for (int j = Nk; j < NW; j++) w[j] <= '0;
            for (int j = 0; j < Nk; j++) begin
                w[j] <= {Key[4*j], Key[4*j+1], Key[4*j+2], Key[4*j+3]};
            end
        end else if (state == EXPAND) begin
            for (int j = 0; j < NW; j++) begin
                if (IW'(j) == i) w[j] <= w_new;
            end
        end
    end
`else
    // schedule storage has no reset; only the control path is cleared
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (accept) begin
                for (int j = 0; j < Nk; j++) begin
                    w[j] <= {Key[4*j], Key[4*j+1], Key[4*j+2], Key[4*j+3]};
                end
            end else if (state == EXPAND) begin
                for (int j = 0; j < NW; j++) begin
                    if (IW'(j) == i) w[j] <= w_new;
                end
            end
        end
    end
`endif

    assign KExp = w;

endmodule

// File: tb/tb_aes_kexp_seq.sv
// tb/tb_aes_kexp_seq.sv - self-checking bench for aes_kexp_seq, AES-128/192/256 instances
// Honours AES_KEXP_ZEROIZE_EN for the zeroize checks

module tb_aes_kexp_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        kv0, kv1, kv2;
    logic        rdy0, rdy1, rdy2;
    logic        val0, val1, val2;
    logic [7:0]  key128 [0:15];
    logic [7:0]  key192 [0:23];
    logic [7:0]  key256 [0:31];
    logic [31:0] kx128 [0:43];
    logic [31:0] kx192 [0:51];
    logic [31:0] kx256 [0:59];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  sbox_m [0:255];
    logic [31:0] mw [0:59];

    always #5 clock = ~clock;

    aes_kexp_seq #(.Nk(4)) dut128 (.clock(clock), .reset(reset), .Key_valid(kv0), .Key_ready(rdy0),
                                   .Key(key128), .KExp(kx128), .KExp_valid(val0));
    aes_kexp_seq #(.Nk(6)) dut192 (.clock(clock), .reset(reset), .Key_valid(kv1), .Key_ready(rdy1),
                                   .Key(key192), .KExp(kx192), .KExp_valid(val1));
    aes_kexp_seq #(.Nk(8)) dut256 (.clock(clock), .reset(reset), .Key_valid(kv2), .Key_ready(rdy2),
                                   .Key(key256), .KExp(kx256), .KExp_valid(val2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // reference: S-box from GF(2^8) inverse plus affine map, schedule from the FIPS-197 loop
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = '0;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, r1, r2, r3, r4, xb, yb;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            xb = 8'(x);
            for (int y = 1; y < 256; y++) begin
                yb = 8'(y);
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            r1 = {inv[6:0], inv[7]};
            r2 = {r1[6:0], r1[7]};
            r3 = {r2[6:0], r2[7]};
            r4 = {r3[6:0], r3[7]};
            sbox_m[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int m = 1; m < n; m++) r = gmul(r, 8'h02);
        return r;
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        for (int n = 0; n < nk; n++) mw[n] = key[255-32*n -: 32];
        for (int n = nk; n < 4 * (nk + 7); n++) begin
            t = mw[n-1];
            if (n % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_of(n / nk), 24'h0};
            else if (nk > 6 && n % nk == 4) t = subw(t);
            mw[n] = mw[n-nk] ^ t;
        end
    endtask

    function automatic logic [31:0] dut_word(input int sel, input int idx);
        case (sel)
            0:       return kx128[idx];
            1:       return kx192[idx];
            default: return kx256[idx];
        endcase
    endfunction

    function automatic logic dut_ready(input int sel);
        case (sel)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic dut_valid(input int sel);
        case (sel)
            0:       return val0;
            1:       return val1;
            default: return val2;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_key(input int sel, input logic [255:0] key);
        for (int b = 0; b < 4 * (4 + 2 * sel); b++) begin
            case (sel)
                0:       key128[b] = key[255-8*b -: 8];
                1:       key192[b] = key[255-8*b -: 8];
                default: key256[b] = key[255-8*b -: 8];
            endcase
        end
    endtask

    task automatic set_kv(input int sel, input logic v);
        case (sel)
            0:       kv0 = v;
            1:       kv1 = v;
            default: kv2 = v;
        endcase
    endtask

    task automatic start(input int sel, input logic [255:0] key, input bit hold);
        set_key(sel, key);
        set_kv(sel, 1'b1);
        tick();
        if (!hold) set_kv(sel, 1'b0);
    endtask

    task automatic wait_done(input int sel, input string tag);
        int  n;
        bit  ready_seen;
        int  nk;
        nk = 4 + 2 * sel;
        n = 0;
        ready_seen = 1'b0;
        while (n < 200) begin
            if (dut_ready(sel)) ready_seen = 1'b1;
            tick();
            n++;
            if (dut_valid(sel)) break;
        end
        check({tag, " latency"}, 32'(n), 32'(4 * (nk + 7) - nk));
        check({tag, " ready low in expand"}, {31'b0, ready_seen}, 32'd0);
        check({tag, " ready in done"}, {31'b0, dut_ready(sel)}, 32'd1);
    endtask

    task automatic check_sched(input int sel, input logic [255:0] key, input string tag);
        int nk;
        nk = 4 + 2 * sel;
        model_expand(nk, key);
        for (int n = 0; n < 4 * (nk + 7); n++) begin
            check($sformatf("%s w[%0d]", tag, n), dut_word(sel, n), mw[n]);
        end
    endtask

    localparam logic [255:0] KEY1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rk, rk2;
        kv0 = 1'b0; kv1 = 1'b0; kv2 = 1'b0;
        set_key(0, '0); set_key(1, '0); set_key(2, '0);
        build_sbox();
        reset = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset ready %0d", s), {31'b0, dut_ready(s)}, 32'd1);
            check($sformatf("reset valid %0d", s), {31'b0, dut_valid(s)}, 32'd0);
        end
`ifdef AES_KEXP_ZEROIZE_EN
        check("zeroize reset w43", kx128[43], 32'h0);
        check("zeroize reset w59", kx256[59], 32'h0);
`endif
        reset = 1'b0;
        tick();

        start(0, KEY1, 1'b0);
        check("t1 ready after accept", {31'b0, rdy0}, 32'd0);
        check("t1 valid after accept", {31'b0, val0}, 32'd0);
        wait_done(0, "t1");
        check("t1 w4", kx128[4], 32'ha0fafe17);
        check("t1 w43", kx128[43], 32'hb6630ca6);
        check_sched(0, KEY1, "t1");

        start(1, KEY2, 1'b0);
        wait_done(1, "t2");
        check("t2 w6", kx192[6], 32'hfe0c91f7);
        check("t2 w51", kx192[51], 32'h01002202);
        check_sched(1, KEY2, "t2");

        start(2, KEY3, 1'b0);
        wait_done(2, "t3");
        check("t3 w8", kx256[8], 32'h9ba35411);
        check("t3 w59", kx256[59], 32'h706c631e);
        check_sched(2, KEY3, "t3");

        rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        start(0, rk, 1'b0);
        for (int e = 1; e < 20; e++) tick();
`ifdef AES_KEXP_ZEROIZE_EN
        check("zeroize mid w43", kx128[43], 32'h0);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4 ready after reset", {31'b0, rdy0}, 32'd1);
        check("t4 valid after reset", {31'b0, val0}, 32'd0);
        tick();
        check("t4 still idle valid", {31'b0, val0}, 32'd0);
        start(0, KEY1, 1'b0);
        wait_done(0, "t4");
        check("t4 w43", kx128[43], 32'hb6630ca6);

        rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        start(0, KEY1, 1'b1);
        set_key(0, rk);
        wait_done(0, "t5a");
        check_sched(0, KEY1, "t5a");
        tick();
        set_kv(0, 1'b0);
        check("t5 valid drops", {31'b0, val0}, 32'd0);
        check("t5 ready drops", {31'b0, rdy0}, 32'd0);
        wait_done(0, "t5b");
        check_sched(0, rk, "t5b");

        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 3; s++) begin
                rk2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                rk2 = rk2 & ~({256{1'b1}} >> (32 * (4 + 2 * s)));
                start(s, rk2, 1'b0);
                wait_done(s, $sformatf("rnd%0d_%0d", r, s));
                check_sched(s, rk2, $sformatf("rnd%0d_%0d", r, s));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
